// File: rtl/core_register_file_mp.sv
// core_register_file_mp
//   Multi-port integer register file for the decode stage. It also holds a
//   per-entry pending scoreboard for RAW hazard detection. After reset, a
//   sweep writes zero to every entry, one entry per cycle, and then ready_o
//   rises.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset (restarts the sweep)
//   ready_o          high once the init sweep has completed
//   read_addr_i      packed read indices, port j at [j*ADDR_WIDTH +: ADDR_WIDTH]
//   read_data_o      packed read data, port j at [j*DATA_WIDTH +: DATA_WIDTH]
//   read_pending_o   per read port: the addressed entry has a pending producer
//   write_addr_i     packed write indices
//   write_data_i     packed write data
//   we_i             per write port enable
//   issue_valid_i    decode issued an instruction writing issue_addr_i
//   issue_addr_i     destination index to mark pending
//
// state | meaning
// INIT  | zero sweep in progress, writes/issues ignored, reads return 0
// RUN   | normal operation, ready_o = 1
module core_register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    output logic                            ready_o,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  read_addr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]  read_data_o,
    output logic [NUM_READ-1:0]             read_pending_o,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_addr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data_i,
    input  logic [NUM_WRITE-1:0]            we_i,
    input  logic                            issue_valid_i,
    input  logic [ADDR_WIDTH-1:0]           issue_addr_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic [DEPTH-1:0]        pend_q, pend_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    run;

    logic [ADDR_WIDTH-1:0]   waddr [NUM_WRITE];
    logic [DATA_WIDTH-1:0]   wdata [NUM_WRITE];
    logic [NUM_WRITE-1:0]    wr_acc;
    logic                    issue_acc;

    // A write is accepted only in RUN and never to the hardwired zero entry.
    for (genvar i = 0; i < NUM_WRITE; i++) begin : g_wr
        assign waddr[i]  = write_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata[i]  = write_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign wr_acc[i] = run && we_i[i] && !(ZERO_REG != 0 && waddr[i] == '0);
    end

    assign issue_acc = run && issue_valid_i && !(ZERO_REG != 0 && issue_addr_i == '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pend_q     <= pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == S_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    // Outputs of the FSM
    always_comb begin
        run     = (state_q == S_RUN);
        ready_o = run;
    end

    // Scoreboard: clears first, then the set, so a new producer issued in
    // the same cycle as the old one's writeback keeps the entry pending.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_WRITE; i++) begin
            if (wr_acc[i]) begin
                pend_d[waddr[i]] = 1'b0;
            end
        end
        if (issue_acc) begin
            pend_d[issue_addr_i] = 1'b1;
        end
    end

    // Storage. Ascending port order makes the highest port win a collision.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (!run) begin
                mem_q[init_cnt_q] <= '0;
            end else begin
                for (int i = 0; i < NUM_WRITE; i++) begin
                    if (wr_acc[i]) begin
                        mem_q[waddr[i]] <= wdata[i];
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rp;

        assign ra = read_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd = mem_q[ra];
            rp = pend_q[ra];
            if (BYPASS != 0) begin
                for (int i = 0; i < NUM_WRITE; i++) begin
                    if (wr_acc[i] && waddr[i] == ra) begin
                        rd = wdata[i];
                        rp = 1'b0;
                    end
                end
            end
            if (!run || (ZERO_REG != 0 && ra == '0)) begin
                rd = '0;
                rp = 1'b0;
            end
        end

        assign read_data_o[j*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign read_pending_o[j]                       = rp;
    end

endmodule

// File: tb/tb_core_register_file_mp.sv
module tb_core_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [1:0]  we;
    logic        iv;
    logic [4:0]  ia;

    logic        rdy0, rdy1;
    logic [63:0] rd0, rd1;
    logic [1:0]  rp0, rp1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Default configuration: 1 write port, bypass on.
    core_register_file_mp dut0 (
        .clk_i(clk), .rst_i(rst), .ready_o(rdy0),
        .read_addr_i(ra), .read_data_o(rd0), .read_pending_o(rp0),
        .write_addr_i(wa[4:0]), .write_data_i(wd[31:0]), .we_i(we[0]),
        .issue_valid_i(iv), .issue_addr_i(ia)
    );

    // Two write ports, no bypass.
    core_register_file_mp #(.NUM_WRITE(2), .BYPASS(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .ready_o(rdy1),
        .read_addr_i(ra), .read_data_o(rd1), .read_pending_o(rp1),
        .write_addr_i(wa), .write_data_i(wd), .we_i(we),
        .issue_valid_i(iv), .issue_addr_i(ia)
    );

    // Reference model: the register contents, the pending set, and the
    // number of cycles since reset was released.
    logic [31:0] mmem  [2][32];
    bit          mpend [2][32];
    int          cnt = 0;
    int          nw  [2] = '{1, 2};
    bit          byp [2] = '{1'b1, 1'b0};

    function automatic bit usable();
        return cnt >= 32;
    endfunction

    function automatic bit bypass_hit(int d, logic [4:0] a, output logic [31:0] v);
        bit hit = 0;
        v = '0;
        if (byp[d] && a != 0) begin
            for (int i = 0; i < nw[d]; i++) begin
                if (we[i] && wa[i*5 +: 5] == a) begin
                    hit = 1;
                    v   = wd[i*32 +: 32];
                end
            end
        end
        return hit;
    endfunction

    function automatic logic [31:0] exp_rd(int d, int j);
        logic [4:0]  a = ra[j*5 +: 5];
        logic [31:0] v;
        if (!usable() || a == 0) return '0;
        if (bypass_hit(d, a, v)) return v;
        return mmem[d][a];
    endfunction

    function automatic logic exp_rp(int d, int j);
        logic [4:0]  a = ra[j*5 +: 5];
        logic [31:0] v;
        if (!usable() || a == 0) return 1'b0;
        if (bypass_hit(d, a, v)) return 1'b0;
        return mpend[d][a];
    endfunction

    task automatic model_update();
        if (rst) begin
            cnt = 0;
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 32; k++) begin
                    mmem[d][k]  = '0;
                    mpend[d][k] = 0;
                end
        end else if (!usable()) begin
            cnt++;
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < nw[d]; i++) begin
                    if (we[i] && wa[i*5 +: 5] != 0) begin
                        mmem[d][wa[i*5 +: 5]]  = wd[i*32 +: 32];
                        mpend[d][wa[i*5 +: 5]] = 0;
                    end
                end
                if (iv && ia != 0) mpend[d][ia] = 1;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Checks outputs mid-cycle, then advances one clock edge.
    task automatic cycle();
        #4;
        check("ready0", {31'd0, rdy0}, {31'd0, usable()});
        check("ready1", {31'd0, rdy1}, {31'd0, usable()});
        for (int j = 0; j < 2; j++) begin
            check($sformatf("rd0[%0d]", j), rd0[j*32 +: 32], exp_rd(0, j));
            check($sformatf("rd1[%0d]", j), rd1[j*32 +: 32], exp_rd(1, j));
            check($sformatf("rp0[%0d]", j), {31'd0, rp0[j]}, {31'd0, exp_rp(0, j)});
            check($sformatf("rp1[%0d]", j), {31'd0, rp1[j]}, {31'd0, exp_rp(1, j)});
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        we = 2'b00;
        iv = 1'b0;
    endtask

    task automatic rand_inputs(bit narrow);
        for (int i = 0; i < 2; i++) begin
            wa[i*5 +: 5] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ra[i*5 +: 5] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wd[i*32 +: 32] = $urandom;
        end
        we = 2'($urandom_range(0, 3));
        iv = 1'($urandom_range(0, 1));
        ia = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endtask

    initial begin
        rst = 1'b1;
        ra = '0; wa = '0; wd = '0; idle(); ia = '0;
        @(posedge clk);
        model_update();
        #1;
        cycle();
        rst = 1'b0;

        // Sweep: inputs ignored, ready low for exactly 32 cycles.
        for (int k = 0; k < 32; k++) begin
            rand_inputs(0);
            cycle();
        end
        idle();
        for (int k = 0; k < 16; k++) begin
            ra = {5'(2*k + 1), 5'(2*k)};
            cycle();
        end

        // Write x5 with same-cycle read, then read it back next cycle.
        ra = {5'd5, 5'd5}; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; we = 2'b01;
        cycle();
        idle();
        cycle();

        // Zero register: write and issue on x0.
        ra = {5'd0, 5'd0}; wa = {5'd0, 5'd0}; wd = {32'h0, 32'h12345678}; we = 2'b01;
        iv = 1'b1; ia = 5'd0;
        cycle();
        idle();
        cycle();

        // Collision on x7 (dut1 has both ports).
        ra = {5'd7, 5'd7}; wa = {5'd7, 5'd7}; wd = {32'h2, 32'h1}; we = 2'b11;
        cycle();
        idle();
        cycle();

        // Scoreboard on x3: issue, writeback, then issue+writeback together.
        ra = {5'd3, 5'd3};
        iv = 1'b1; ia = 5'd3;
        cycle();
        idle();
        cycle();
        wa = {5'd0, 5'd3}; wd = {32'd0, 32'hCAFE0003}; we = 2'b01;
        cycle();
        idle();
        cycle();
        iv = 1'b1; ia = 5'd3; we = 2'b01; wd = {32'd0, 32'h00000033};
        cycle();
        idle();
        cycle();

        // Randomized traffic, narrow addresses first to provoke hazards.
        for (int k = 0; k < 300; k++) begin
            rand_inputs(1);
            cycle();
        end
        for (int k = 0; k < 200; k++) begin
            rand_inputs(0);
            cycle();
        end

        // Reset mid-sweep at init_cnt = 10.
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_inputs(0);
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rand_inputs(0);
            cycle();
        end
        idle();
        for (int k = 0; k < 16; k++) begin
            ra = {5'(2*k + 1), 5'(2*k)};
            cycle();
        end
        for (int k = 0; k < 50; k++) begin
            rand_inputs(1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
